boot_loader: RTL and testbench

- Writer side of the memory boot-load port: accepts program bytes from the HPS over a valid/ready stream.
- Drives BootLoad, BootLoadAddress and WriteToMemory to fill program region 0..7 of the 16x8 memory.
- Optionally reads the region back through ReadFromMemory and checks a sum.
- Sits between the HPS bridge and the memory block; holds the CPU off (BootLoad high) while loading.

---
 rtl/boot_pkg.sv | 20 ++
 rtl/boot_sum_accum.sv | 25 ++
 rtl/boot_loader.sv | 172 +++++++++++++++++
 tb/tb_boot_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader.
// Build with BOOT_VERIFY_EN defined to enable the readback verify pass.
package boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      VERIFY,
      DONE,
      ERROR
   } state_t;

   localparam int PROG_DEPTH_DEF = 8;
   // Cycles from issuing a readback address to sampling ReadFromMemory.
   localparam int RB_LATENCY     = 2;
   // Wide enough to count 0..8 inclusive.
   localparam int CNT_W          = 4;

endpackage

// File: rtl/boot_sum_accum.sv
// 8-bit clear/add accumulator with mod-256 wrap; clear has priority over add.
module boot_sum_accum (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       add,
   input  logic [7:0] value,
   output logic [7:0] sum
);

   logic [7:0] sum_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum_reg <= 8'h00;
      end else if (clear) begin
         sum_reg <= 8'h00;
      end else if (add) begin
         sum_reg <= sum_reg + value;
      end
   end

   assign sum = sum_reg;

endmodule

// File: rtl/boot_loader.sv
// Boot-load writer: streams HPS bytes into program region 0..PROG_DEPTH-1 of the memory.
// Define BOOT_VERIFY_EN to add a readback pass that compares the region sum against checksum.
module boot_loader
   import boot_pkg::*;
#(
   parameter int PROG_DEPTH = PROG_DEPTH_DEF,
   parameter int ADDR_W     = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              BootLoad,
   output logic [ADDR_W-1:0] BootLoadAddress,
   output logic [7:0]        WriteToMemory,
   input  logic [7:0]        ReadFromMemory,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [7:0]        checksum
);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        wdata_reg;
   logic              boot_load_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              session_start;
   logic              accept;
   logic              last_byte;

   assign session_start = (state_reg == IDLE) && start;
   assign accept        = (state_reg == LOAD) && byte_valid;
   assign last_byte     = accept && (cnt_reg == CNT_W'(PROG_DEPTH - 1));

   boot_sum_accum u_write_sum (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (session_start),
      .add     (accept),
      .value   (byte_data),
      .sum     (checksum)
   );

`ifdef BOOT_VERIFY_EN
   logic [RB_LATENCY-1:0] vld_reg;
   logic [CNT_W-1:0]      rb_cnt_reg;
   logic [7:0]            rb_sum;
   logic                  issue;
   logic                  rb_done;
   logic                  rb_match;
   logic                  error_reg;

   // SETTLE issues address 0; VERIFY issues the rest until the counter reaches PROG_DEPTH.
   assign issue    = (state_reg == SETTLE) ||
                     ((state_reg == VERIFY) && (cnt_reg != CNT_W'(PROG_DEPTH)));
   assign rb_done  = (rb_cnt_reg == CNT_W'(PROG_DEPTH));
   assign rb_match = (rb_sum == checksum);

   boot_sum_accum u_read_sum (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_reg == SETTLE),
      .add     (vld_reg[RB_LATENCY-1]),
      .value   (ReadFromMemory),
      .sum     (rb_sum)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vld_reg    <= '0;
         rb_cnt_reg <= '0;
         error_reg  <= 1'b0;
      end else begin
         vld_reg <= {vld_reg[RB_LATENCY-2:0], issue};
         if (state_reg == SETTLE) begin
            rb_cnt_reg <= '0;
         end else if (vld_reg[RB_LATENCY-1]) begin
            rb_cnt_reg <= rb_cnt_reg + CNT_W'(1);
         end
         if (session_start) begin
            error_reg <= 1'b0;
         end else if (state_next == ERROR) begin
            error_reg <= 1'b1;
         end
      end
   end

   assign error = error_reg;
`else
   logic unused_readback;
   assign unused_readback = ^ReadFromMemory;
   assign error           = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (start) state_next = LOAD;
         LOAD:   if (last_byte) state_next = SETTLE;
`ifdef BOOT_VERIFY_EN
         SETTLE: state_next = VERIFY;
         VERIFY: if (rb_done) state_next = rb_match ? DONE : ERROR;
`else
         SETTLE: state_next = DONE;
         VERIFY: state_next = IDLE;
`endif
         DONE:   state_next = IDLE;
         ERROR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // DONE and ERROR only flag the outcome; the register goes straight back to IDLE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else if ((state_next == DONE) || (state_next == ERROR)) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_reg       <= '0;
         addr_reg      <= '0;
         wdata_reg     <= 8'h00;
         boot_load_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         boot_load_reg <= (state_next == LOAD) || (state_next == SETTLE);
         busy_reg      <= (state_next == LOAD) || (state_next == SETTLE) ||
                          (state_next == VERIFY);
         if (session_start) begin
            done_reg <= 1'b0;
         end else if (state_next == DONE) begin
            done_reg <= 1'b1;
         end
         if (session_start) begin
            cnt_reg <= '0;
         end else if (accept) begin
            wdata_reg <= byte_data;
            addr_reg  <= ADDR_W'(cnt_reg);
            cnt_reg   <= cnt_reg + CNT_W'(1);
         end
`ifdef BOOT_VERIFY_EN
         else if (state_reg == SETTLE) begin
            addr_reg <= '0;
            cnt_reg  <= CNT_W'(1);
         end else if (issue) begin
            addr_reg <= ADDR_W'(cnt_reg);
            cnt_reg  <= cnt_reg + CNT_W'(1);
         end
`endif
      end
   end

   assign byte_ready      = (state_reg == LOAD);
   assign BootLoad        = boot_load_reg;
   assign BootLoadAddress = addr_reg;
   assign WriteToMemory   = wdata_reg;
   assign busy            = busy_reg;
   assign done            = done_reg;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: memory model plus a sum-of-bytes reference model.
module tb_boot_loader;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       byte_ready;
   logic       BootLoad;
   logic [3:0] BootLoadAddress;
   logic [7:0] WriteToMemory;
   logic [7:0] ReadFromMemory;
   logic       busy, done, error;
   logic [7:0] checksum;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   boot_loader dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .byte_valid      (byte_valid),
      .byte_data       (byte_data),
      .byte_ready      (byte_ready),
      .BootLoad        (BootLoad),
      .BootLoadAddress (BootLoadAddress),
      .WriteToMemory   (WriteToMemory),
      .ReadFromMemory  (ReadFromMemory),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .checksum        (checksum)
   );

   // 16x8 memory: writes while BootLoad is high, clears 8..15 then, registered read.
   logic [7:0] mem [16];
   logic [7:0] rd_q = 8'h00;
   bit         stuck0 = 1'b0;

   always @(posedge clk) begin
      if (BootLoad) begin
         for (int i = 8; i < 16; i++) mem[i] <= 8'h00;
         mem[BootLoadAddress] <= WriteToMemory;
      end
      rd_q <= mem[BootLoadAddress];
   end
   assign ReadFromMemory = stuck0 ? (rd_q | 8'h01) : rd_q;

   int bl_cycles = 0;
   int busy_cycles = 0;
   always @(posedge clk) begin
      bl_cycles   <= bl_cycles + int'(BootLoad);
      busy_cycles <= busy_cycles + int'(busy);
   end

   logic [7:0] pat [8];
   int         gaps_ready;
   bit         timed_out;

   function automatic logic [7:0] expected_sum();
      int s = 0;
      for (int i = 0; i < 8; i++) s += int'(pat[i]);
      return 8'(s % 256);
   endfunction

   task automatic random_pat();
      for (int i = 0; i < 8; i++) pat[i] = 8'($urandom);
   endtask

   // mode 0: valid held, 1: valid every other cycle, 2: random gaps.
   task automatic load_session(input int mode, input int n_bytes, input int pulse_at);
      int idx = 0;
      int n = 0;
      gaps_ready = 0;
      timed_out  = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (idx < n_bytes && n < 200) begin
         case (mode)
            0:       byte_valid = 1'b1;
            1:       byte_valid = ((n % 2) == 0);
            default: byte_valid = ($urandom_range(0, 2) != 0);
         endcase
         byte_data = byte_valid ? pat[idx] : 8'($urandom);
         start     = (idx == pulse_at);
         if (!byte_ready) gaps_ready++;
         if (byte_valid && byte_ready) idx++;
         n++;
         @(negedge clk);
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      if (idx < n_bytes) timed_out = 1'b1;
      if (n_bytes == 8) begin
         while (busy && n < 400) begin
            @(negedge clk);
            n++;
         end
         if (busy) timed_out = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = 1'b1;
      byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if ({byte_ready, BootLoad, busy, done, error} !== 5'b0) begin
         $display("FAIL reset_flags got=%b want=00000", {byte_ready, BootLoad, busy, done, error});
      end else n_pass++;
      n_total++;
      if ({BootLoadAddress, WriteToMemory, checksum} !== 20'h0) begin
         $display("FAIL reset_data got=%h/%h/%h want=0/00/00", BootLoadAddress, WriteToMemory, checksum);
      end else n_pass++;
      start = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || byte_ready !== 1'b0) begin
         $display("FAIL reset_release got busy=%b ready=%b want 0/0", busy, byte_ready);
      end else n_pass++;
      byte_valid = 1'b0;
      $display("test_reset done");
   endtask

   task automatic check_session(input string name, input logic [7:0] want_sum);
      n_total++;
      if (timed_out !== 1'b0) $display("FAIL %s_timeout got=1 want=0", name);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_total++;
         if (mem[i] !== pat[i]) $display("FAIL %s_mem[%0d] got=%h want=%h", name, i, mem[i], pat[i]);
         else n_pass++;
      end
      n_total++;
      if (checksum !== want_sum) $display("FAIL %s_checksum got=%h want=%h", name, checksum, want_sum);
      else n_pass++;
      n_total++;
      if ({done, error, busy, BootLoad} !== 4'b1000) begin
         $display("FAIL %s_status got done/err/busy/bl=%b want=1000", name, {done, error, busy, BootLoad});
      end else n_pass++;
      $display("%s: checksum=%h done=%b error=%b", name, checksum, done, error);
   endtask

   task automatic test_basic();
      int bl0, bz0, want_busy;
      for (int i = 0; i < 8; i++) pat[i] = 8'h11 + 8'(i);
      bl0 = bl_cycles;
      bz0 = busy_cycles;
      load_session(0, 8, -1);
      check_session("basic", expected_sum());
      n_total++;
      if (bl_cycles - bl0 != 9) $display("FAIL basic_bootload_cycles got=%0d want=9", bl_cycles - bl0);
      else n_pass++;
`ifdef BOOT_VERIFY_EN
      want_busy = 9 + 8 + 2;
`else
      want_busy = 9;
`endif
      n_total++;
      if (busy_cycles - bz0 != want_busy) begin
         $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_cycles - bz0, want_busy);
      end else n_pass++;
   endtask

   task automatic test_toggle();
      for (int i = 0; i < 8; i++) pat[i] = 8'h11 + 8'(i);
      load_session(1, 8, -1);
      check_session("toggle", expected_sum());
      n_total++;
      if (gaps_ready != 0) $display("FAIL toggle_ready_gaps got=%0d want=0", gaps_ready);
      else n_pass++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 8; i++) pat[i] = 8'hFF;
      load_session(0, 8, -1);
      check_session("wrap", 8'hF8);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         random_pat();
         load_session(2, 8, -1);
         check_session("random", expected_sum());
      end
   endtask

   task automatic test_idle_ignore();
      logic [7:0] cs;
      cs = checksum;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_data  = 8'($urandom);
         @(negedge clk);
         n_total++;
         if ({byte_ready, BootLoad, busy} !== 3'b000 || checksum !== cs) begin
            $display("FAIL idle_ignore got ready/bl/busy=%b cs=%h want 000 cs=%h",
                     {byte_ready, BootLoad, busy}, checksum, cs);
         end else n_pass++;
      end
      byte_valid = 1'b0;
      $display("idle_ignore: checksum=%h", checksum);
   endtask

   task automatic test_reset_mid();
      random_pat();
      load_session(0, 3, -1);
      reset_n = 1'b0;
      @(negedge clk);
      n_total++;
      if ({BootLoad, busy, done, error} !== 4'b0 || checksum !== 8'h00) begin
         $display("FAIL reset_mid got bl/busy/done/err=%b cs=%h want 0000 cs=00",
                  {BootLoad, busy, done, error}, checksum);
      end else n_pass++;
      reset_n = 1'b1;
      @(negedge clk);
      random_pat();
      load_session(0, 8, -1);
      check_session("after_reset", expected_sum());
   endtask

   task automatic test_start_ignored();
      random_pat();
      load_session(2, 8, 3);
      check_session("start_in_load", expected_sum());
   endtask

`ifdef BOOT_VERIFY_EN
   task automatic test_verify_error();
      int bl0, bz0;
      for (int i = 0; i < 8; i++) pat[i] = 8'h11 + 8'(i);
      stuck0 = 1'b1;
      bl0 = bl_cycles;
      bz0 = busy_cycles;
      load_session(0, 8, -1);
      stuck0 = 1'b0;
      n_total++;
      if ({error, done, busy} !== 3'b100 || timed_out) begin
         $display("FAIL verify_error got err/done/busy=%b timeout=%b want 100/0", {error, done, busy}, timed_out);
      end else n_pass++;
      n_total++;
      if ((busy_cycles - bz0) - (bl_cycles - bl0) != 10) begin
         $display("FAIL verify_busy_tail got=%0d want=10", (busy_cycles - bz0) - (bl_cycles - bl0));
      end else n_pass++;
      $display("verify_error: error=%b done=%b", error, done);
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_wrap();
      test_idle_ignore();
`ifdef BOOT_VERIFY_EN
      test_verify_error();
`endif
      test_random();
      test_reset_mid();
      test_start_ignored();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
